bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Slot-based memory bus arbiter: one reserved CPU slot per eight-slot frame,
// remaining slots serve a single outstanding SPI-originated transaction.
module bus_arbiter #(
  parameter logic [2:0] CPU_SLOT = 3'd7
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        clk_setup_i,
  input  logic        clk_enable_i,
  input  logic        clk_disable_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic        spi_req_i,
  input  logic [15:0] spi_addr_i,
  input  logic        spi_we_i,
  input  logic [7:0]  spi_wr_data_i,
  input  logic [7:0]  bus_data_i,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  output logic        ram_oe_o,
  output logic        ram_we_o,
  output logic        cpu_owner_o,
  output logic        spi_busy_o,
  output logic        spi_ack_o,
  output logic [7:0]  spi_rd_data_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACTIVE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_SPI
  } own_t;

  state_t      state_q, state_d;
  own_t        own_q, own_d;
  logic [2:0]  slot_q, slot_d;
  logic [2:0]  nxt_slot;
  logic        we_q, we_d;
  logic        fin_q, fin_d;
  logic        pend_q, pend_d;
  logic [15:0] sa_q, sa_d;
  logic        swe_q, swe_d;
  logic [7:0]  sdat_q, sdat_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  bdat_q, bdat_d;
  logic        doe_q, doe_d;
  logic        oe_q, oe_d;
  logic        rwe_q, rwe_d;
  logic        ack_q, ack_d;
  logic [7:0]  rd_q, rd_d;

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      own_q   <= OWN_NONE;
      slot_q  <= 3'd0;
      we_q    <= 1'b0;
      fin_q   <= 1'b0;
      pend_q  <= 1'b0;
      sa_q    <= 16'h0000;
      swe_q   <= 1'b0;
      sdat_q  <= 8'h00;
      addr_q  <= 16'h0000;
      bdat_q  <= 8'h00;
      doe_q   <= 1'b0;
      oe_q    <= 1'b0;
      rwe_q   <= 1'b0;
      ack_q   <= 1'b0;
      rd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      slot_q  <= slot_d;
      we_q    <= we_d;
      fin_q   <= fin_d;
      pend_q  <= pend_d;
      sa_q    <= sa_d;
      swe_q   <= swe_d;
      sdat_q  <= sdat_d;
      addr_q  <= addr_d;
      bdat_q  <= bdat_d;
      doe_q   <= doe_d;
      oe_q    <= oe_d;
      rwe_q   <= rwe_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    slot_d   = slot_q;
    we_d     = we_q;
    fin_d    = 1'b0;
    pend_d   = pend_q;
    sa_d     = sa_q;
    swe_d    = swe_q;
    sdat_d   = sdat_q;
    addr_d   = addr_q;
    bdat_d   = bdat_q;
    doe_d    = doe_q;
    oe_d     = oe_q;
    rwe_d    = rwe_q;
    ack_d    = 1'b0;
    rd_d     = rd_q;
    nxt_slot = slot_q + 3'd1;

    if (spi_req_i && !pend_q) begin
      pend_d = 1'b1;
      sa_d   = spi_addr_i;
      swe_d  = spi_we_i;
      sdat_d = spi_wr_data_i;
    end

    if (clk_setup_i) begin
      slot_d = nxt_slot;
    end

    // Strobes and write data are held one clock past disable.
    if (fin_q) begin
      own_d  = OWN_NONE;
      oe_d   = 1'b0;
      rwe_d  = 1'b0;
      doe_d  = 1'b0;
      bdat_d = 8'h00;
    end

    unique case (state_q)
      S_IDLE: begin
        if (clk_setup_i) begin
          state_d = S_SETUP;
          if (nxt_slot == CPU_SLOT) begin
            own_d  = OWN_CPU;
            addr_d = cpu_addr_i;
            we_d   = cpu_we_i;
          end else if (pend_q) begin
            own_d  = OWN_SPI;
            addr_d = sa_q;
            we_d   = swe_q;
            doe_d  = swe_q;
            bdat_d = swe_q ? sdat_q : 8'h00;
          end else begin
            own_d = OWN_NONE;
            we_d  = 1'b0;
          end
        end
      end
      S_SETUP: begin
        if (clk_enable_i) begin
          state_d = S_ACTIVE;
          if (own_q != OWN_NONE) begin
            rwe_d = we_q;
            oe_d  = !we_q;
          end
        end
      end
      S_ACTIVE: begin
        if (clk_disable_i) begin
          state_d = S_IDLE;
          fin_d   = 1'b1;
          if (own_q == OWN_SPI) begin
            ack_d  = 1'b1;
            pend_d = 1'b0;
            if (!we_q) begin
              rd_d = bus_data_i;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_addr_o    = addr_q;
  assign bus_data_o    = bdat_q;
  assign bus_data_oe_o = doe_q;
  assign ram_oe_o      = oe_q;
  assign ram_we_o      = rwe_q;
  assign cpu_owner_o   = (own_q == OWN_CPU);
  assign spi_busy_o    = pend_q | ack_q;
  assign spi_ack_o     = ack_q;
  assign spi_rd_data_o = rd_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a local timing generator drives the slot
// strobes and a queue of expected SPI transactions is checked at service/ack.
module tb_bus_arbiter;

  logic        clk_sys_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        clk_setup_i = 1'b0;
  logic        clk_enable_i = 1'b0;
  logic        clk_disable_i = 1'b0;
  logic [15:0] cpu_addr_i = 16'hC0DE;
  logic        cpu_we_i = 1'b0;
  logic        spi_req_i = 1'b0;
  logic [15:0] spi_addr_i = 16'h0000;
  logic        spi_we_i = 1'b0;
  logic [7:0]  spi_wr_data_i = 8'h00;
  logic [7:0]  bus_data_i = 8'hEE;
  logic [15:0] bus_addr_o;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic        ram_oe_o;
  logic        ram_we_o;
  logic        cpu_owner_o;
  logic        spi_busy_o;
  logic        spi_ack_o;
  logic [7:0]  spi_rd_data_o;

  bus_arbiter dut (
    .clk_sys_i     (clk_sys_i),
    .reset_i       (reset_i),
    .clk_setup_i   (clk_setup_i),
    .clk_enable_i  (clk_enable_i),
    .clk_disable_i (clk_disable_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_we_i      (cpu_we_i),
    .spi_req_i     (spi_req_i),
    .spi_addr_i    (spi_addr_i),
    .spi_we_i      (spi_we_i),
    .spi_wr_data_i (spi_wr_data_i),
    .bus_data_i    (bus_data_i),
    .bus_addr_o    (bus_addr_o),
    .bus_data_o    (bus_data_o),
    .bus_data_oe_o (bus_data_oe_o),
    .ram_oe_o      (ram_oe_o),
    .ram_we_o      (ram_we_o),
    .cpu_owner_o   (cpu_owner_o),
    .spi_busy_o    (spi_busy_o),
    .spi_ack_o     (spi_ack_o),
    .spi_rd_data_o (spi_rd_data_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  rd;
    int          slot;
  } txn_t;

  txn_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cnt = 0;
  int   tb_slot = 0;
  int   len = 0;
  bit   run = 0;
  bit   aborting = 0;
  bit   prev_ack = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_strobes();
    clk_setup_i   = run && (cnt == 0);
    clk_enable_i  = run && (cnt == 2);
    clk_disable_i = run && (cnt == 6);
    bus_data_i    = (q.size() != 0) ? q[0].rd : 8'hEE;
  endtask

  task automatic tick();
    txn_t t;
    @(posedge clk_sys_i);
    #1;
    if (reset_i) tb_slot = 0;
    else if (clk_setup_i) tb_slot = (tb_slot + 1) % 8;
    if (run) cnt = (cnt + 1) % 8;
    chk("cpu_owner", 32'(cpu_owner_o), 32'(tb_slot == 7 && cnt != 0));
    if (ram_we_o || ram_oe_o) len++;
    else begin
      if (len != 0 && !aborting) chk("strobe_len", len, 5);
      len = 0;
    end
    if (len == 1) begin
      if (cpu_owner_o) begin
        chk("cpu_addr", 32'(bus_addr_o), 32'hC0DE);
        chk("cpu_we", 32'(ram_we_o), 32'(cpu_we_i));
        chk("cpu_doe", 32'(bus_data_oe_o), 0);
      end else begin
        chk("spi_pending", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("spi_slot", tb_slot, q[0].slot);
          chk("spi_addr", 32'(bus_addr_o), 32'(q[0].addr));
          chk("spi_we", 32'(ram_we_o), 32'(q[0].we));
          chk("spi_doe", 32'(bus_data_oe_o), 32'(q[0].we));
          if (q[0].we) chk("spi_wdata", 32'(bus_data_o), 32'(q[0].wd));
        end
      end
    end
    if (spi_ack_o) begin
      chk("ack_single", 32'(prev_ack), 0);
      chk("ack_phase", cnt, 7);
      chk("ack_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        t = q.pop_front();
        if (!t.we) chk("rd_data", 32'(spi_rd_data_o), 32'(t.rd));
      end
    end
    prev_ack = spi_ack_o;
    if (q.size() == 0 && tb_slot != 7 && cnt >= 1 && cnt <= 6)
      chk("idle_quiet", 32'({ram_we_o, ram_oe_o, bus_data_oe_o,
                              spi_ack_o, spi_busy_o}), 0);
    drive_strobes();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_at(input int s, input int c);
    int n = 0;
    while (!(tb_slot == s && cnt == c) && n < 300) begin
      tick();
      n++;
    end
    chk("wait_reached", 32'(tb_slot == s && cnt == c), 1);
  endtask

  task automatic spi_req(input logic [15:0] a, input logic we,
                         input logic [7:0] wd, input logic [7:0] rd,
                         input int slot, input bit push);
    spi_addr_i    = a;
    spi_we_i      = we;
    spi_wr_data_i = wd;
    spi_req_i     = 1'b1;
    if (push) q.push_back('{a, we, wd, rd, slot});
    tick();
    spi_req_i = 1'b0;
  endtask

  task automatic drain(input bit expect_clear);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      chk("busy_hold", 32'(spi_busy_o), 1);
      tick();
      n++;
    end
    chk("drain_done", q.size(), 0);
    chk("busy_ack", 32'(spi_busy_o), 1);
    if (expect_clear) begin
      tick();
      chk("busy_clr", 32'(spi_busy_o), 0);
    end
  endtask

  initial begin
    ticks(3);
    chk("rst_addr", 32'(bus_addr_o), 0);
    chk("rst_rd", 32'(spi_rd_data_o), 0);
    chk("rst_flags", 32'({bus_data_o, bus_data_oe_o, ram_oe_o, ram_we_o,
                          cpu_owner_o, spi_busy_o, spi_ack_o}), 0);
    reset_i = 1'b0;
    ticks(5);
    chk("no_action", 32'({ram_oe_o, ram_we_o, cpu_owner_o}), 0);

    run = 1;
    drive_strobes();
    ticks(72);
    cpu_we_i = 1'b1;
    ticks(64);
    cpu_we_i = 1'b0;

    wait_at(2, 3);
    spi_req(16'h8000, 1'b1, 8'hA5, 8'h00, 3, 1);
    drain(1);

    wait_at(4, 3);
    spi_req(16'h1234, 1'b0, 8'h00, 8'h5C, 5, 1);
    drain(1);
    ticks(10);
    chk("rd_hold", 32'(spi_rd_data_o), 32'h5C);

    wait_at(6, 3);
    spi_req(16'h0042, 1'b0, 8'h00, 8'h3C, 0, 1);
    drain(1);

    wait_at(1, 3);
    spi_req(16'h0100, 1'b1, 8'h11, 8'h00, 2, 1);
    spi_req(16'h0200, 1'b1, 8'h22, 8'h00, 2, 0);
    wait_at(2, 7);
    chk("ack_coincide", 32'(spi_ack_o), 1);
    spi_req(16'h0300, 1'b0, 8'h00, 8'h77, 3, 1);
    drain(0);

    wait_at(3, 0);
    chk("setup_coincide", 32'(clk_setup_i), 1);
    spi_req(16'h0400, 1'b0, 8'h00, 8'h99, 5, 1);
    drain(1);

    wait_at(5, 3);
    spi_req(16'h4444, 1'b1, 8'h5A, 8'h00, 6, 1);
    wait_at(6, 4);
    chk("abort_we_pre", 32'(ram_we_o), 1);
    reset_i  = 1'b1;
    aborting = 1;
    tick();
    aborting = 0;
    reset_i  = 1'b0;
    q.delete();
    chk("abort_we", 32'(ram_we_o), 0);
    chk("abort_busy", 32'(spi_busy_o), 0);
    chk("abort_ack", 32'(spi_ack_o), 0);
    chk("abort_rd", 32'(spi_rd_data_o), 0);
    ticks(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
